// File: rtl/game_control.sv
// Game sequencer: attract / start / serve-wait / play cycle, coin debounce and serve-delay timing.
// All outputs are registered decodes of the next state, so they follow the causing input by one cycle.
module game_control #(
    parameter int SERVE_FRAMES  = 102,
    parameter int COIN_DEBOUNCE = 16
) (
    input  logic CLK_DRV,
    input  logic RESET,
    input  logic COIN,
    input  logic V_RESET,
    input  logic MISS_N,
    input  logic STOP_G,
    output logic SRST,
    output logic SRST_N,
    output logic ATTRACT,
    output logic ATTRACT_N,
    output logic RUN,
    output logic SERVE_N
);

    localparam int FW = $clog2(SERVE_FRAMES + 1);
    localparam int DW = $clog2(COIN_DEBOUNCE + 1);

    typedef enum logic [1:0] {S_ATTRACT, S_START, S_SERVE_WAIT, S_PLAY} state_t;

    logic          coin_p0, coin_p1;
    logic [DW-1:0] deb_cnt;
    logic          coin_deb, coin_deb_d;
    logic          coin_acc;
    logic          miss_q;
    logic          miss_evt;

    state_t        state, state_n;
    logic [FW-1:0] frame_cnt, frame_n;
    logic          start_vr, start_vr_n;

    logic srst_d, attract_d, run_d, serve_n_d;

    // Stage p0/p1: coin synchroniser, then debounce on the synced level
    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            coin_p0    <= 1'b0;
            coin_p1    <= 1'b0;
            deb_cnt    <= '0;
            coin_deb   <= 1'b0;
            coin_deb_d <= 1'b0;
            miss_q     <= 1'b1;
        end else begin
            coin_p0    <= COIN;
            coin_p1    <= coin_p0;
            coin_deb_d <= coin_deb;
            miss_q     <= MISS_N;
            if (coin_p1 == coin_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(COIN_DEBOUNCE - 1)) begin
                deb_cnt  <= '0;
                coin_deb <= coin_p1;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign coin_acc = coin_deb & ~coin_deb_d;
    assign miss_evt = miss_q & ~MISS_N;

    always_comb begin
        state_n    = state;
        frame_n    = frame_cnt;
        start_vr_n = start_vr;
        if (coin_acc) begin
            // A coin restarts the game from any state; a coincident V_RESET is not counted.
            state_n    = S_START;
            start_vr_n = 1'b0;
        end else begin
            case (state)
                S_START: begin
                    if (V_RESET) begin
                        if (start_vr) begin
                            state_n = S_SERVE_WAIT;
                            frame_n = '0;
                        end else begin
                            start_vr_n = 1'b1;
                        end
                    end
                end
                S_SERVE_WAIT: begin
                    if (STOP_G) begin
                        state_n = S_ATTRACT;
                    end else if (V_RESET) begin
                        if (frame_cnt != FW'(SERVE_FRAMES))
                            frame_n = frame_cnt + 1'b1;
                        if (frame_cnt == FW'(SERVE_FRAMES - 1))
                            state_n = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (STOP_G) begin
                        state_n = S_ATTRACT;
                    end else if (miss_evt) begin
                        state_n = S_SERVE_WAIT;
                        frame_n = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        srst_d    = (state_n == S_START);
        attract_d = (state_n == S_ATTRACT);
        run_d     = (state_n == S_SERVE_WAIT) || (state_n == S_PLAY);
        serve_n_d = (state_n == S_ATTRACT) || (state_n == S_PLAY);
    end

    // Stage p2: state register and registered output decode
    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            state     <= S_ATTRACT;
            frame_cnt <= '0;
            start_vr  <= 1'b0;
            SRST      <= 1'b1;
            SRST_N    <= 1'b0;
            ATTRACT   <= 1'b1;
            ATTRACT_N <= 1'b0;
            RUN       <= 1'b0;
            SERVE_N   <= 1'b1;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_n;
            start_vr  <= start_vr_n;
            SRST      <= srst_d;
            SRST_N    <= ~srst_d;
            ATTRACT   <= attract_d;
            ATTRACT_N <= ~attract_d;
            RUN       <= run_d;
            SERVE_N   <= serve_n_d;
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: directed scenarios plus random traffic, all checked
// cycle by cycle against a rule-level reference model of the sequencer.
module tb_game_control;

    localparam int SF = 3;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, coin = 1'b0, v_reset = 1'b0, miss_n = 1'b1, stop_g = 1'b0;
    logic srst, srst_n, attract, attract_n, run, serve_n;

    game_control #(.SERVE_FRAMES(SF), .COIN_DEBOUNCE(CD)) dut (
        .CLK_DRV(clk), .RESET(rst), .COIN(coin), .V_RESET(v_reset),
        .MISS_N(miss_n), .STOP_G(stop_g),
        .SRST(srst), .SRST_N(srst_n), .ATTRACT(attract), .ATTRACT_N(attract_n),
        .RUN(run), .SERVE_N(serve_n)
    );

    always #5 clk = ~clk;

    wire [5:0] obs = {srst, srst_n, attract, attract_n, run, serve_n};

    localparam logic [5:0] O_RESET   = 6'b101001;
    localparam logic [5:0] O_ATTRACT = 6'b011001;
    localparam logic [5:0] O_START   = 6'b100100;
    localparam logic [5:0] O_SW      = 6'b010110;
    localparam logic [5:0] O_PLAY    = 6'b010111;

    int checks = 0;
    int errors = 0;

    typedef enum {M_ATTRACT, M_START, M_SW, M_PLAY} mode_t;
    mode_t m_mode = M_ATTRACT;
    bit    m_in_rst = 1'b1;
    bit    m_deb, m_deb_prev, m_miss_prev = 1'b1;
    int    m_vr, m_frames;
    bit    hist[$];

    int vr_phase = 0;
    bit vr_auto  = 1'b1;
    int vr_seen  = 0;

    function automatic logic [5:0] expected();
        if (m_in_rst) return O_RESET;
        case (m_mode)
            M_START: return O_START;
            M_SW:    return O_SW;
            M_PLAY:  return O_PLAY;
            default: return O_ATTRACT;
        endcase
    endfunction

    // Reference: coin accepted when the last CD synchronised samples all oppose the
    // debounced level; game rules applied with the inputs seen at this edge.
    task automatic model_step();
        bit acc, evt, flip;
        if (rst) begin
            m_in_rst = 1'b1; m_mode = M_ATTRACT; m_deb = 1'b0; m_deb_prev = 1'b0;
            m_miss_prev = 1'b1; m_vr = 0; m_frames = 0; hist.delete();
            return;
        end
        m_in_rst = 1'b0;
        acc = m_deb && !m_deb_prev;
        evt = m_miss_prev && !miss_n;
        if (acc) begin
            m_mode = M_START; m_vr = 0;
        end else begin
            case (m_mode)
                M_START: if (v_reset) begin
                    m_vr++;
                    if (m_vr == 2) begin m_mode = M_SW; m_frames = 0; end
                end
                M_SW: if (stop_g) m_mode = M_ATTRACT;
                      else if (v_reset) begin
                          m_frames++;
                          if (m_frames == SF) m_mode = M_PLAY;
                      end
                M_PLAY: if (stop_g) m_mode = M_ATTRACT;
                        else if (evt) begin m_mode = M_SW; m_frames = 0; end
                default: ;
            endcase
        end
        m_miss_prev = miss_n;
        hist.push_back(coin);
        if (hist.size() > CD + 2) void'(hist.pop_front());
        m_deb_prev = m_deb;
        if (hist.size() == CD + 2) begin
            flip = 1'b1;
            for (int i = 0; i < CD; i++) if (hist[i] == m_deb) flip = 1'b0;
            if (flip) m_deb = !m_deb;
        end
    endtask

    task automatic step();
        if (vr_auto) begin
            v_reset  = (vr_phase == 99);
            vr_phase = (vr_phase + 1) % 100;
        end
        @(posedge clk);
        if (v_reset && !rst) vr_seen++;
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (obs !== O_RESET) begin errors++; $display("FAIL reset_hold: got %b want %b", obs, O_RESET); end
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== O_ATTRACT) begin errors++; $display("FAIL reset_release: got %b want %b", obs, O_ATTRACT); end
    endtask

    task automatic test_coin_glitch();
        coin = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) coin = 1'b0;
            step();
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL coin_glitch: got %b want %b", obs, expected()); end
        end
        checks++;
        if (obs !== O_ATTRACT) begin errors++; $display("FAIL coin_glitch_state: got %b want %b", obs, O_ATTRACT); end
    endtask

    task automatic test_coin_start();
        int lat = 0;
        int v0;
        coin = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL coin_start: got %b want %b", obs, expected()); end
            if (lat == 0 && obs === O_START) lat = k;
        end
        checks++;
        if (lat != 7) begin errors++; $display("FAIL coin_latency: got %0d want 7", lat); end
        v0 = vr_seen - ((vr_phase >= 1 && vr_phase <= 13) ? 1 : 0);
        for (int i = 0; i < 400 && obs === O_START; i++) begin
            if (i == 10) coin = 1'b0;
            step();
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL start_hold: got %b want %b", obs, expected()); end
        end
        coin = 1'b0;
        checks++;
        if (obs !== O_SW) begin errors++; $display("FAIL start_exit: got %b want %b", obs, O_SW); end
        checks++;
        if (vr_seen - v0 != 2) begin errors++; $display("FAIL start_vresets: got %0d want 2", vr_seen - v0); end
    endtask

    task automatic test_serve();
        int v0 = vr_seen;
        for (int i = 0; i < 400 && obs === O_SW; i++) begin
            miss_n = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL serve_wait: got %b want %b", obs, expected()); end
        end
        miss_n = 1'b1;
        checks++;
        if (obs !== O_PLAY) begin errors++; $display("FAIL serve_to_play: got %b want %b", obs, O_PLAY); end
        checks++;
        if (vr_seen - v0 != SF) begin errors++; $display("FAIL serve_frames: got %0d want %0d", vr_seen - v0, SF); end
    endtask

    task automatic test_miss_hold();
        int entries = 0;
        logic [5:0] prev;
        repeat (2) step();
        miss_n = 1'b0;
        for (int i = 0; i < 440; i++) begin
            if (i == 40) miss_n = 1'b1;
            prev = obs;
            step();
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL miss_hold: got %b want %b", obs, expected()); end
            if (prev === O_PLAY && obs === O_SW) entries++;
            if (i >= 40 && obs === O_PLAY) break;
        end
        checks++;
        if (entries != 1) begin errors++; $display("FAIL miss_entries: got %0d want 1", entries); end
        checks++;
        if (obs !== O_PLAY) begin errors++; $display("FAIL miss_replay: got %b want %b", obs, O_PLAY); end
    endtask

    task automatic test_stop();
        stop_g = 1'b1;
        miss_n = 1'b0;
        step();
        checks++;
        if (obs !== O_ATTRACT) begin errors++; $display("FAIL stop_vs_miss: got %b want %b", obs, O_ATTRACT); end
        for (int i = 0; i < 250; i++) begin
            miss_n = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (obs !== O_ATTRACT) begin errors++; $display("FAIL stop_attract_hold: got %b want %b", obs, O_ATTRACT); end
        end
        miss_n = 1'b1;
    endtask

    task automatic test_coin_restart();
        bit seen = 1'b0;
        int v0 = 0;
        stop_g = 1'b0;
        coin   = 1'b1;
        for (int i = 0; i < 1000 && obs !== O_PLAY; i++) begin
            if (i == 10) coin = 1'b0;
            step();
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL restart_setup: got %b want %b", obs, expected()); end
        end
        coin = 1'b0;
        checks++;
        if (obs !== O_PLAY) begin errors++; $display("FAIL restart_reach_play: got %b want %b", obs, O_PLAY); end
        coin = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i == 10) coin = 1'b0;
            step();
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL restart_run: got %b want %b", obs, expected()); end
            if (!seen && obs === O_START) begin
                seen = 1'b1; stop_g = 1'b1; v0 = vr_seen;
            end else if (seen && obs !== O_START) begin
                break;
            end
        end
        coin = 1'b0;
        checks++;
        if (!seen || obs !== O_SW) begin errors++; $display("FAIL restart_exit: got %b want %b", obs, O_SW); end
        checks++;
        if (vr_seen - v0 != 2) begin errors++; $display("FAIL restart_vresets: got %0d want 2", vr_seen - v0); end
        step();
        checks++;
        if (obs !== O_ATTRACT) begin errors++; $display("FAIL restart_stop: got %b want %b", obs, O_ATTRACT); end
        stop_g = 1'b0;
    endtask

    task automatic test_random();
        int hold = 0;
        vr_auto = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            if (hold == 0) begin
                coin = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            v_reset = ($urandom_range(0, 19) == 0);
            miss_n  = ($urandom_range(0, 9) != 0);
            stop_g  = ($urandom_range(0, 59) == 0);
            step();
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL random_cycle %0d: got %b want %b", i, obs, expected()); end
        end
        rst = 1'b0;
        v_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_coin_glitch();
        test_coin_start();
        test_serve();
        test_miss_hold();
        test_stop();
        test_coin_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
